// File: rtl/fifo_err_inj_pkg.sv
// Shared encodings, state enum and LFSR constants for the error-injection sequencer.
package fifo_err_inj_pkg;

    typedef enum logic [1:0] {
        MODE_SINGLE   = 2'd0,
        MODE_PERIODIC = 2'd1,
        MODE_RANDOM   = 2'd2,
        MODE_RSVD     = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        KIND_SBIT = 2'd0,
        KIND_DBIT = 2'd1,
        KIND_ALT  = 2'd2,
        KIND_RSVD = 2'd3
    } kind_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_PULSE = 2'd2,
        ST_HOLD  = 2'd3
    } state_e;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps x^16+x^14+x^13+x^11 map to state bits 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic lfsr_feedback(input logic [15:0] v);
        return ^(v & LFSR_TAPS);
    endfunction

endpackage

// File: rtl/fifo_err_inj_seq_lfsr.sv
// 16-bit Fibonacci LFSR with run enable; supplies the random inter-pulse gaps.
module err_inj_lfsr
    import fifo_err_inj_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    output logic [15:0] lfsr_o
);

    logic [15:0] lfsr_d;
    logic [15:0] lfsr_q;

    always_comb begin
        if (en_i) begin
            lfsr_d = {lfsr_q[14:0], lfsr_feedback(lfsr_q)};
        end else begin
            lfsr_d = lfsr_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_o = lfsr_q;

endmodule

// File: rtl/fifo_err_inj_seq.sv
// Single-cycle ECC error-injection pulse sequencer for one TMR FIFO lane.
// Random mode (LFSR gaps) is built only when FIFO_ERR_INJ_RANDOM_EN is defined.
module fifo_err_inj_seq
    import fifo_err_inj_pkg::*;
#(
    parameter int PW      = 16,
    parameter int CW      = 16,
    parameter int HOLDOFF = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          enable_i,
    input  logic [1:0]    mode_i,
    input  logic [1:0]    kind_i,
    input  logic          trig_i,
    input  logic [PW-1:0] period_i,
    input  logic          clr_i,
    output logic          injectsbiterr_o,
    output logic          injectdbiterr_o,
    output logic          busy_o,
    output logic [CW-1:0] sbit_cnt_o,
    output logic [CW-1:0] dbit_cnt_o
);

    localparam int            HW        = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLDOFF - 1);
    localparam logic [PW-1:0] HOLD_IVAL = PW'(HOLDOFF + 1);

    state_e        state_q, state_d, run_state_s;
    mode_e         mode_q, mode_d;
    kind_e         kind_q, kind_d;
    logic [PW-1:0] ival_q, ival_d, ival_s;
    logic [PW-1:0] wcnt_q, wcnt_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [PW-1:0] gap_s;
    logic          alt_dbit_q, alt_dbit_d;
    logic          pulse_s, sel_dbit_s;
    logic          sbit_q, sbit_d, dbit_q, dbit_d, busy_q, busy_d;
    logic [CW-1:0] sbit_cnt_q, sbit_cnt_d, dbit_cnt_q, dbit_cnt_d;

    assign ival_s = (period_i < HOLD_IVAL) ? HOLD_IVAL : period_i;

`ifdef FIFO_ERR_INJ_RANDOM_EN
    logic [15:0] lfsr_s;
    logic        unused_lfsr_hi_s;

    err_inj_lfsr u_lfsr (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (enable_i),
        .lfsr_o (lfsr_s)
    );

    assign unused_lfsr_hi_s = ^lfsr_s[15:8];
    // Extra cycles beyond the minimum HOLDOFF+1 spacing before the next pulse.
    assign gap_s = (mode_q == MODE_RANDOM) ? PW'(lfsr_s[7:0]) : (ival_q - HOLD_IVAL);
`else
    assign gap_s = ival_q - HOLD_IVAL;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            mode_q     <= MODE_SINGLE;
            kind_q     <= KIND_SBIT;
            ival_q     <= HOLD_IVAL;
            wcnt_q     <= '0;
            hcnt_q     <= '0;
            alt_dbit_q <= 1'b0;
            sbit_q     <= 1'b0;
            dbit_q     <= 1'b0;
            busy_q     <= 1'b0;
            sbit_cnt_q <= '0;
            dbit_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            kind_q     <= kind_d;
            ival_q     <= ival_d;
            wcnt_q     <= wcnt_d;
            hcnt_q     <= hcnt_d;
            alt_dbit_q <= alt_dbit_d;
            sbit_q     <= sbit_d;
            dbit_q     <= dbit_d;
            busy_q     <= busy_d;
            sbit_cnt_q <= sbit_cnt_d;
            dbit_cnt_q <= dbit_cnt_d;
        end
    end

    always_comb begin
        run_state_s = state_q;
        mode_d      = mode_q;
        kind_d      = kind_q;
        ival_d      = ival_q;
        wcnt_d      = wcnt_q;
        hcnt_d      = hcnt_q;
        case (state_q)
            ST_IDLE: begin
                // Config is re-captured every enabled IDLE cycle, so the exit edge wins.
                mode_d = mode_e'(mode_i);
                kind_d = (kind_i == KIND_RSVD) ? KIND_SBIT : kind_e'(kind_i);
                ival_d = ival_s;
                case (mode_e'(mode_i))
                    MODE_SINGLE: begin
                        if (trig_i) begin
                            run_state_s = ST_PULSE;
                        end else begin
                            run_state_s = ST_IDLE;
                        end
                    end
                    MODE_PERIODIC: begin
                        run_state_s = ST_WAIT;
                        wcnt_d      = ival_s - PW'(1);
                    end
`ifdef FIFO_ERR_INJ_RANDOM_EN
                    MODE_RANDOM: begin
                        run_state_s = ST_WAIT;
                        wcnt_d      = PW'(lfsr_s[7:0]) + PW'(HOLDOFF);
                    end
`endif
                    default: run_state_s = ST_IDLE;
                endcase
            end
            ST_WAIT: begin
                if (wcnt_q == '0) begin
                    run_state_s = ST_PULSE;
                end else begin
                    wcnt_d = wcnt_q - PW'(1);
                end
            end
            ST_PULSE: begin
                run_state_s = ST_HOLD;
                hcnt_d      = '0;
            end
            ST_HOLD: begin
                if (hcnt_q == HOLD_LAST) begin
                    // A zero gap means the hold alone already gives the spacing: pulse directly.
                    if (mode_q == MODE_SINGLE) begin
                        run_state_s = ST_IDLE;
                    end else if (gap_s == '0) begin
                        run_state_s = ST_PULSE;
                    end else begin
                        run_state_s = ST_WAIT;
                        wcnt_d      = gap_s - PW'(1);
                    end
                end else begin
                    hcnt_d = hcnt_q + HW'(1);
                end
            end
            default: run_state_s = ST_IDLE;
        endcase
        state_d = enable_i ? run_state_s : ST_IDLE;
    end

    always_comb begin
        pulse_s = (state_d == ST_PULSE);
        case (kind_d)
            KIND_SBIT: sel_dbit_s = 1'b0;
            KIND_DBIT: sel_dbit_s = 1'b1;
            KIND_ALT:  sel_dbit_s = alt_dbit_q;
            default:   sel_dbit_s = 1'b0;
        endcase
        sbit_d     = pulse_s & ~sel_dbit_s;
        dbit_d     = pulse_s & sel_dbit_s;
        alt_dbit_d = (pulse_s && (kind_d == KIND_ALT)) ? ~alt_dbit_q : alt_dbit_q;
        busy_d     = (state_d != ST_IDLE);
        // Clear has priority, so a pulse coinciding with clr_i is never counted.
        if (clr_i) begin
            sbit_cnt_d = '0;
            dbit_cnt_d = '0;
        end else begin
            sbit_cnt_d = (sbit_q && (sbit_cnt_q != '1)) ? sbit_cnt_q + CW'(1) : sbit_cnt_q;
            dbit_cnt_d = (dbit_q && (dbit_cnt_q != '1)) ? dbit_cnt_q + CW'(1) : dbit_cnt_q;
        end
    end

    assign injectsbiterr_o = sbit_q;
    assign injectdbiterr_o = dbit_q;
    assign busy_o          = busy_q;
    assign sbit_cnt_o      = sbit_cnt_q;
    assign dbit_cnt_o      = dbit_cnt_q;

endmodule

// File: tb/tb_fifo_err_inj_seq.sv
// Scoreboard bench for fifo_err_inj_seq: expected pulses are queued from a timing model,
// a negedge monitor pops and compares every pulse the DUT emits.
module tb_fifo_err_inj_seq;

    localparam int PW = 16;
    localparam int CW = 4;
    localparam int HOLDOFF = 4;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          enable_i = 1'b0;
    logic [1:0]    mode_i = 2'd0;
    logic [1:0]    kind_i = 2'd0;
    logic          trig_i = 1'b0;
    logic [PW-1:0] period_i = '0;
    logic          clr_i = 1'b0;
    logic          injectsbiterr_o, injectdbiterr_o, busy_o;
    logic [CW-1:0] sbit_cnt_o, dbit_cnt_o;

    typedef struct {
        int t;
        bit dbit;
    } ev_t;

    int  tests = 0;
    int  fails = 0;
    int  cyc = 0;
    bit  alt_m = 1'b0;
    bit  rand_phase = 1'b0;
    ev_t exp_q[$];
    int  rec_q[$];
    int  first_q[$];

    fifo_err_inj_seq #(.PW(PW), .CW(CW), .HOLDOFF(HOLDOFF)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .enable_i        (enable_i),
        .mode_i          (mode_i),
        .kind_i          (kind_i),
        .trig_i          (trig_i),
        .period_i        (period_i),
        .clr_i           (clr_i),
        .injectsbiterr_o (injectsbiterr_o),
        .injectdbiterr_o (injectdbiterr_o),
        .busy_o          (busy_o),
        .sbit_cnt_o      (sbit_cnt_o),
        .dbit_cnt_o      (dbit_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        tests++;
        if (act < lo || act > hi) begin
            fails++;
            $display("FAIL %s: got %0d, expected within [%0d,%0d]", name, act, lo, hi);
        end
    endtask

    always @(negedge clk_i) begin
        ev_t e;
        if (injectsbiterr_o || injectdbiterr_o) begin
            check("one_hot", int'(injectsbiterr_o && injectdbiterr_o), 0);
            if (rand_phase) begin
                rec_q.push_back(cyc);
            end else if (exp_q.size() == 0) begin
                check("unexpected_pulse_cycle", cyc, -1);
            end else begin
                e = exp_q.pop_front();
                check("pulse_cycle", cyc, e.t);
                check("pulse_is_dbit", int'(injectdbiterr_o), int'(e.dbit));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk_i);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b1; enable_i = 1'b0; trig_i = 1'b0; clr_i = 1'b0;
        alt_m = 1'b0;
        tick(2);
        rst_i = 1'b0;
        tick(1);
    endtask

    task automatic clear_counts();
        @(negedge clk_i);
        clr_i = 1'b1;
        tick(1);
        clr_i = 1'b0;
    endtask

    // Returns the edge index at which enable is first sampled high in IDLE.
    task automatic start_run(input int m, input int k, input int p, output int t0);
        @(negedge clk_i);
        mode_i = 2'(m); kind_i = 2'(k); period_i = PW'(p);
        enable_i = 1'b1;
        t0 = cyc + 1;
    endtask

    // Reference: pulses every max(period, HOLDOFF+1) cycles; alternate kind starts with single-bit.
    task automatic expect_periodic(input int t0, input int period, input int kind, input int n);
        int  ival;
        ev_t e;
        ival = (period > HOLDOFF + 1) ? period : HOLDOFF + 1;
        for (int k = 1; k <= n; k++) begin
            e.t = t0 + k * ival;
            if (kind == 1) begin
                e.dbit = 1'b1;
            end else if (kind == 2) begin
                e.dbit = alt_m;
                alt_m  = ~alt_m;
            end else begin
                e.dbit = 1'b0;
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic run_random();
        int t0;
        do_reset();
        rec_q.delete();
        rand_phase = 1'b1;
        start_run(2, 0, 0, t0);
        wait_until(t0 + 2000);
        enable_i = 1'b0;
        tick(2);
        rand_phase = 1'b0;
        for (int i = 0; i < rec_q.size(); i++) rec_q[i] = rec_q[i] - t0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  t0;
        ev_t e;

        do_reset();
        check("rst_sbit", int'(injectsbiterr_o), 0);
        check("rst_dbit", int'(injectdbiterr_o), 0);
        check("rst_busy", int'(busy_o), 0);
        check("rst_sbit_cnt", int'(sbit_cnt_o), 0);
        check("rst_dbit_cnt", int'(dbit_cnt_o), 0);

        // Single-bit shot, plus a trigger during HOLD that must be dropped
        start_run(0, 0, 0, t0);
        tick(3);
        check("single_idle_busy", int'(busy_o), 0);
        trig_i = 1'b1;
        t0 = cyc + 1;
        e.t = t0; e.dbit = 1'b0;
        exp_q.push_back(e);
        tick(1);
        trig_i = 1'b0;
        check("single_busy_on", int'(busy_o), 1);
        wait_until(t0 + 1);
        check("single_sbit_cnt", int'(sbit_cnt_o), 1);
        wait_until(t0 + 2);
        trig_i = 1'b1;
        tick(1);
        trig_i = 1'b0;
        wait_until(t0 + HOLDOFF);
        check("single_busy_last", int'(busy_o), 1);
        wait_until(t0 + HOLDOFF + 1);
        check("single_busy_off", int'(busy_o), 0);
        tick(8);
        check("single_sbit_cnt_final", int'(sbit_cnt_o), 1);
        check("single_queue_empty", exp_q.size(), 0);
        enable_i = 1'b0;

        // Periodic double-bit, period 10 then period 2 (clamped to HOLDOFF+1)
        clear_counts();
        start_run(1, 1, 10, t0);
        expect_periodic(t0, 10, 1, 5);
        wait_until(t0 + 54);
        enable_i = 1'b0;
        wait_until(t0 + 60);
        check("per10_dbit_cnt", int'(dbit_cnt_o), 5);
        check("per10_sbit_cnt", int'(sbit_cnt_o), 0);
        check("per10_queue_empty", exp_q.size(), 0);

        clear_counts();
        start_run(1, 1, 2, t0);
        expect_periodic(t0, 2, 1, 4);
        wait_until(t0 + 22);
        enable_i = 1'b0;
        wait_until(t0 + 30);
        check("per2_dbit_cnt", int'(dbit_cnt_o), 4);
        check("per2_queue_empty", exp_q.size(), 0);

        // Alternate kind: S,D,S,D
        clear_counts();
        start_run(1, 2, 8, t0);
        expect_periodic(t0, 8, 2, 4);
        wait_until(t0 + 33);
        enable_i = 1'b0;
        wait_until(t0 + 40);
        check("alt_sbit_cnt", int'(sbit_cnt_o), 2);
        check("alt_dbit_cnt", int'(dbit_cnt_o), 2);
        check("alt_queue_empty", exp_q.size(), 0);

        // Saturation at 2^CW-1, then clear on a pulse cycle
        clear_counts();
        start_run(1, 0, 5, t0);
        expect_periodic(t0, 5, 0, 20);
        wait_until(t0 + 101);
        enable_i = 1'b0;
        wait_until(t0 + 105);
        check("sat_sbit_cnt", int'(sbit_cnt_o), 15);
        check("sat_queue_empty", exp_q.size(), 0);

        start_run(1, 0, 5, t0);
        expect_periodic(t0, 5, 0, 1);
        wait_until(t0 + 5);
        clr_i = 1'b1;
        tick(1);
        clr_i = 1'b0;
        check("clr_on_pulse_cnt", int'(sbit_cnt_o), 0);
        tick(1);
        check("clr_on_pulse_cnt_after", int'(sbit_cnt_o), 0);
        enable_i = 1'b0;
        tick(10);
        check("clr_queue_empty", exp_q.size(), 0);

        // Abort in WAIT: back to IDLE next cycle, no pulse
        start_run(1, 0, 10, t0);
        wait_until(t0 + 3);
        check("abort_busy_wait", int'(busy_o), 1);
        enable_i = 1'b0;
        tick(1);
        check("abort_busy_idle", int'(busy_o), 0);
        wait_until(t0 + 15);
        check("abort_sbit_cnt", int'(sbit_cnt_o), 0);

        // Asynchronous reset during a pulse
        start_run(1, 0, 6, t0);
        expect_periodic(t0, 6, 0, 2);
        wait_until(t0 + 12);
        check("prerst_sbit", int'(injectsbiterr_o), 1);
        check("prerst_cnt", int'(sbit_cnt_o), 1);
        #2;
        rst_i = 1'b1;
        #1;
        check("midrst_sbit", int'(injectsbiterr_o), 0);
        check("midrst_busy", int'(busy_o), 0);
        check("midrst_cnt", int'(sbit_cnt_o), 0);
        enable_i = 1'b0;
        alt_m = 1'b0;
        tick(1);
        rst_i = 1'b0;
        tick(2);
        check("rst_queue_empty", exp_q.size(), 0);

`ifdef FIFO_ERR_INJ_RANDOM_EN
        run_random();
        first_q = rec_q;
        check("rand_has_pulses", int'(first_q.size() > 1), 1);
        for (int i = 0; i < first_q.size(); i++) begin
            if (i == 0) check_range("rand_first_gap", first_q[0], HOLDOFF + 1, HOLDOFF + 256);
            else check_range("rand_spacing", first_q[i] - first_q[i-1], HOLDOFF + 1, HOLDOFF + 256);
        end
        run_random();
        check("rand_repeat_count", rec_q.size(), first_q.size());
        for (int i = 0; i < first_q.size() && i < rec_q.size(); i++) begin
            check("rand_repeat_time", rec_q[i], first_q[i]);
        end
`else
        do_reset();
        start_run(2, 0, 0, t0);
        tick(300);
        check("rand_disabled_busy", int'(busy_o), 0);
        check("rand_disabled_cnt", int'(sbit_cnt_o), 0);
        enable_i = 1'b0;
        tick(2);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fifo_err_inj_seq.md
# fifo_err_inj_seq

Error-injection sequencer that drives the `injectsbiterr`/`injectdbiterr` inputs of a TMR FIFO lane with ECC protection, one lane per instance. It is the upstream stage of the lane. It generates single-cycle injection pulses in three modes: single-shot, periodic and pseudo-random. It guarantees a minimum idle gap between pulses and counts what it injected, so the bench and on-board monitors can reconcile injected events against reported `fifo_err`/`pg_warn` events.

## Interface
Parameters:
- `PW`, 16, width of the period input and of the internal down-counter
- `CW`, 16, width of each injection counter
- `HOLDOFF`, 4, minimum number of idle cycles after each pulse (≥1)

Ports:
- `clk_i`  in  1  system clock (100 MHz domain)
- `rst_i`  in  1  reset, asynchronous, active-high
- `enable_i`  in  1  level; run enable
- `mode_i`  in  2  0 = single, 1 = periodic, 2 = random, 3 = reserved (no injection)
- `kind_i`  in  2  0 = single-bit, 1 = double-bit, 2 = alternate (single-bit first), 3 = treated as 0
- `trig_i`  in  1  one-cycle request; used in single mode only
- `period_i`  in  PW  pulse spacing for periodic mode, in cycles
- `clr_i`  in  1  synchronous clear of both counters
- `injectsbiterr_o`  out  1  single-bit injection pulse
- `injectdbiterr_o`  out  1  double-bit injection pulse
- `busy_o`  out  1  high in any state other than IDLE
- `sbit_cnt_o`  out  CW  saturating count of single-bit pulses issued
- `dbit_cnt_o`  out  CW  saturating count of double-bit pulses issued

## Operation
- **States:** IDLE, WAIT, PULSE, HOLD.
- **Reset values:** state = IDLE; all outputs = 0; LFSR = 16'hACE1; alternate toggle = single-bit.
- **Config sampling:** `mode_i`, `kind_i` and `period_i` are latched on the IDLE exit edge. Later changes are ignored until the next return to IDLE.
- **Effective interval:** `ival = max(period_i, HOLDOFF+1)`. A `period_i` of 0 yields `HOLDOFF+1`.
- **IDLE transitions (all require `enable_i`=1):**
  - single mode with `trig_i`=1 → PULSE
  - periodic mode → WAIT, counter loaded with `ival-1`
  - random mode → WAIT, counter loaded with `lfsr[7:0] + HOLDOFF`
  - reserved mode → stays in IDLE
- **WAIT:** counter decrements each cycle. At 0 the next state is PULSE.
- **PULSE:** exactly one output is high for exactly one cycle, then → HOLD.
  - Kind 0 drives `injectsbiterr_o`; kind 1 drives `injectdbiterr_o`.
  - Kind 2 drives the output selected by the toggle, and the toggle flips after each pulse.
- **HOLD:** lasts `HOLDOFF` cycles.
  - Single mode → IDLE.
  - Periodic mode → WAIT, reloaded so that pulse-to-pulse spacing is exactly `ival`.
  - Random mode → WAIT with a fresh LFSR draw.
- **LFSR:** 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1. Advances every cycle while `enable_i`=1.
- **`enable_i`=0** in any state forces IDLE on the next edge. A pulse already on the outputs finishes its single cycle; no new pulse starts.
- **`trig_i`** outside IDLE, or in any non-single mode, is ignored and not queued.
- **Counters:** `cnt <= clr_i ? 0 : (pulse && cnt != all-ones) ? cnt+1 : cnt`. Clear wins over a simultaneous pulse, so that pulse is not counted.
- **Invariant:** `injectsbiterr_o & injectdbiterr_o` is never 1.

## Timing
- All outputs are registered.
- **Single mode:** `trig_i` sampled high at edge T → pulse high during cycle T+1 → `busy_o` high from T+1 through T+1+HOLDOFF → IDLE.
- **Periodic mode:** `enable_i` sampled high in IDLE at edge T → first pulse at T+`ival`, then every `ival` cycles.
- **Random mode:** spacing between pulses is in [HOLDOFF+1, HOLDOFF+256] cycles.
- **Counter latency:** a counter reflects a pulse on the cycle after the pulse.
- **Reset:** assertion mid-pulse drops the outputs immediately (asynchronous).

## Configuration
- `FIFO_ERR_INJ_RANDOM_EN`
  - Defined: LFSR instantiated and mode 2 behaves as described.
  - Undefined: no LFSR logic; mode 2 behaves as mode 3 (stays in IDLE, no pulses).

## Structure
- **Package `fifo_err_inj_pkg`** holds:
  - mode and kind encodings
  - state enum
  - LFSR seed (16'hACE1) and tap constant
- **Sub-module `err_inj_lfsr`:** 16-bit LFSR with enable. Instantiated only under `FIFO_ERR_INJ_RANDOM_EN`.

## Test plan
- **Single-bit shot:** reset, `enable_i`=1, mode 0, kind 0, one-cycle `trig_i` at edge T → `injectsbiterr_o` high only in cycle T+1, `sbit_cnt_o`=1, `busy_o` low at T+6 (HOLDOFF=4). A `trig_i` at T+3 → no second pulse.
- **Periodic double-bit:** mode 1, kind 1, `period_i`=10, enable for 55 cycles → 5 `injectdbiterr_o` pulses spaced exactly 10 cycles, `dbit_cnt_o`=5, `sbit_cnt_o`=0. Repeat with `period_i`=2 → spacing 5.
- **Alternate:** mode 1, kind 2, `period_i`=8, 4 pulses → order S,D,S,D, both counters = 2, never both outputs high.
- **Random:** with `FIFO_ERR_INJ_RANDOM_EN`, mode 2, kind 0, 2000 cycles → every spacing within [5, 260]; sequence identical across two runs from reset. Without the macro → zero pulses.
- **Clear and saturation:** CW=4, periodic `period_i`=5, 20 pulses → `sbit_cnt_o` holds at 15. `clr_i` on a pulse cycle → counter reads 0 on the next cycle.
- **Abort and reset:** drop `enable_i` in WAIT → IDLE next cycle with no pulse. Assert `rst_i` mid-PULSE → outputs 0 immediately and counters 0.
